down_timer_sched: RTL and testbench

//   Round-robin scheduler that shares one WIDTH-bit down-counter among N_REQ

---
 rtl/down_timer_sched.sv | 116 +++++++++++
 tb/tb_down_timer_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/down_timer_sched.sv
// Round-robin owner arbitration for a single shared down-counter.
// The owner gets a done pulse when its countdown reaches zero, or cancelled when it is aborted.
module down_timer_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_val,
  input  logic                   tick,
  input  logic                   cancel,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       count,
  output logic [N_REQ-1:0]       done,
  output logic                   cancelled
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, COUNT, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, win, cand;
  logic              found;
  logic [WIDTH-1:0]  load_arr [N_REQ];
  logic [N_REQ-1:0]  grant_nxt, done_nxt;
  logic              busy_nxt, cancelled_nxt;
  logic [WIDTH-1:0]  count_nxt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) load_arr[i] = load_val[i*WIDTH +: WIDTH];
  end

  // Search upward from the last owner so the previous winner is considered last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_nxt     = grant;
    busy_nxt      = busy;
    count_nxt     = count;
    done_nxt      = '0;
    cancelled_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = ONE << win;
          count_nxt = load_arr[win];
          busy_nxt  = 1'b1;
          ptr_nxt   = win;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (cancel) begin
          grant_nxt     = '0;
          busy_nxt      = 1'b0;
          count_nxt     = '0;
          cancelled_nxt = 1'b1;
          state_nxt     = IDLE;
        end else if (tick) begin
          // A count of 0 or 1 expires on this tick; the counter never wraps.
          if (count <= WIDTH'(1)) begin
            count_nxt = '0;
            done_nxt  = grant;
            state_nxt = RELEASE;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= PW'(N_REQ - 1);
      grant     <= '0;
      busy      <= 1'b0;
      count     <= '0;
      done      <= '0;
      cancelled <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      count     <= count_nxt;
      done      <= done_nxt;
      cancelled <= cancelled_nxt;
    end
  end

endmodule

// File: tb/tb_down_timer_sched.sv
// Bench for down_timer_sched: directed scenarios plus random traffic against an owner/countdown model.
module tb_down_timer_sched;
  localparam int N = 4;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] load_val = '0;
  logic           tick = 1'b0;
  logic           cancel = 1'b0;
  logic [N-1:0]   grant, done;
  logic           busy, cancelled;
  logic [W-1:0]   count;

  down_timer_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .req(req), .load_val(load_val), .tick(tick),
    .cancel(cancel), .grant(grant), .busy(busy), .count(count), .done(done),
    .cancelled(cancelled)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: who owns the counter, its remaining value, and whether the done cycle is showing.
  int           owner = -1;
  int           cnt = 0;
  bit           rel = 1'b0;
  int           ptr = N - 1;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic         e_busy = 1'b0, e_cancelled = 1'b0;
  logic [W-1:0] e_count = '0;

  task automatic model_reset();
    owner = -1; cnt = 0; rel = 1'b0; ptr = N - 1;
    e_grant = '0; e_done = '0; e_busy = 1'b0; e_cancelled = 1'b0; e_count = '0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    e_cancelled = 1'b0;
    if (rel) begin
      rel = 1'b0; owner = -1; cnt = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (owner < 0 && req[c]) begin
          owner = c; ptr = c; cnt = int'(load_val[c*W +: W]);
        end
      end
    end else if (cancel) begin
      owner = -1; cnt = 0; e_cancelled = 1'b1;
    end else if (tick) begin
      if (cnt <= 1) begin cnt = 0; rel = 1'b1; end
      else cnt = cnt - 1;
    end
    e_grant = (owner >= 0) ? (N'(1) << owner) : '0;
    e_busy  = (owner >= 0) && !rel;
    e_busy  = e_busy || rel;
    e_count = W'(cnt);
    e_done  = rel ? e_grant : '0;
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (grant === e_grant) else begin errors++; $error("FAIL %s.grant observed=%b expected=%b", tag, grant, e_grant); end
    checks++;
    assert (busy === e_busy) else begin errors++; $error("FAIL %s.busy observed=%b expected=%b", tag, busy, e_busy); end
    checks++;
    assert (count === e_count) else begin errors++; $error("FAIL %s.count observed=%0d expected=%0d", tag, count, e_count); end
    checks++;
    assert (done === e_done) else begin errors++; $error("FAIL %s.done observed=%b expected=%b", tag, done, e_done); end
    checks++;
    assert (cancelled === e_cancelled) else begin errors++; $error("FAIL %s.cancelled observed=%b expected=%b", tag, cancelled, e_cancelled); end
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clock);
    #1;
    check_all("reset_held");
    reset = 1'b1;
  endtask

  logic [N-1:0] gq[$];
  logic [N-1:0] prev_g;
  logic [N-1:0] exp_order [5];
  int           canc_seen, done0_seen;
  bit           canc_armed;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    // Reset held with random activity on the inputs
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("reset0");
    for (int i = 0; i < 5; i++) begin
      req = N'($urandom); tick = 1'($urandom); cancel = 1'($urandom);
      load_val = (N*W)'($urandom);
      cyc("reset_rand");
    end
    req = '0; tick = 1'b0; cancel = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("idle_after_reset");

    // Single requester, load 3, continuous tick
    load_val = '0; load_val[0*W +: W] = 4'd3; tick = 1'b1; req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc("single_load3");
      if (e_done != 0) req = '0;
    end
    for (int i = 0; i < 2; i++) cyc("single_tail");

    // All four requesting with load 1: strict rotation
    reset_pulse();
    load_val = {4'd1, 4'd1, 4'd1, 4'd1}; tick = 1'b1; req = 4'b1111;
    prev_g = '0;
    for (int i = 0; i < 18; i++) begin
      cyc("rotation");
      if (grant != 0 && prev_g == 0) gq.push_back(grant);
      prev_g = grant;
    end
    checks++;
    assert (gq.size() >= 5) else begin errors++; $error("FAIL rotation_len observed=%0d expected>=5", gq.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) begin
        checks++;
        assert (gq[i] === exp_order[i]) else begin errors++; $error("FAIL rotation_order[%0d] observed=%b expected=%b", i, gq[i], exp_order[i]); end
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++) cyc("rotation_drain");

    // Sparse ticks: count must hold between strobes
    load_val = '0; load_val[1*W +: W] = 4'd2; req = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      tick = (i % 3 == 2);
      cyc("sparse_tick");
      if (e_done != 0) req = '0;
    end
    tick = 1'b0;
    for (int i = 0; i < 2; i++) cyc("sparse_tail");

    // Cancel coinciding with the expiring tick
    load_val = '0; load_val[0*W +: W] = 4'd5; load_val[2*W +: W] = 4'd3;
    req = 4'b0101; tick = 1'b1; canc_armed = 1'b1; canc_seen = 0; done0_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cancel = canc_armed && e_busy && !rel && (e_count == 4'd1) && e_grant[0];
      if (cancel) canc_armed = 1'b0;
      cyc("cancel_expiry");
      cancel = 1'b0;
      if (cancelled) canc_seen++;
      if (done[0]) done0_seen++;
      if (e_done != 0) req = req & ~e_done;
    end
    checks++;
    assert (canc_seen == 1) else begin errors++; $error("FAIL cancel_pulses observed=%0d expected=1", canc_seen); end
    req = '0;
    for (int i = 0; i < 3; i++) cyc("cancel_tail");

    // Async reset in the middle of a countdown
    load_val = {4'd9, 4'd9, 4'd9, 4'd9}; req = 4'b0100; tick = 1'b1;
    for (int i = 0; i < 4; i++) cyc("pre_reset_count");
    reset_pulse();
    req = 4'b1111;
    cyc("post_reset_grant");
    checks++;
    assert (grant === 4'b0001) else begin errors++; $error("FAIL post_reset_winner observed=%b expected=0001", grant); end
    reset_pulse();
    req = '0;

    // Load 0 expires on the first tick; max load counts all the way down
    load_val = '0; req = 4'b0001; tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("load_zero");
      if (e_done != 0) req = '0;
    end
    load_val[3*W +: W] = 4'hF; req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      cyc("load_max");
      if (e_done != 0) req = '0;
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom); load_val = (N*W)'($urandom);
      tick = ($urandom_range(0, 3) != 0); cancel = ($urandom_range(0, 15) == 0);
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
